uart_tx: RTL and testbench

//   8N1 UART transmitter; the transmit-side counterpart of async_receiver on the same serial link.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, bit-period derivation and counter sizing.
// Used by uart_tx and async_receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic LINE_IDLE = 1'b1;

   function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
      return clk_freq / baud;
   endfunction

   // Bits needed to hold 0..n-1, never less than 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int i = 0; i < 32; i++) begin
         if ((32'd1 << w) < n) w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: down-counter reloaded every DIV cycles, restarted by i_clr at frame start.
// o_tick marks the last cycle of a bit period; o_tick_next marks the cycle before it.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_tick,
   output logic o_tick_next
);

   localparam int unsigned   CW     = cnt_width(DIV);
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || (r_cnt == '0)) begin
         r_cnt <= RELOAD;
      end else begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

   assign o_tick      = (r_cnt == '0);
   assign o_tick_next = (r_cnt == CW'(1));

endmodule

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter, LSB first, idle-high line, one byte per valid/ready handshake.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
//
// state    | meaning
// ST_IDLE  | line high, tx_ready=1, waiting for tx_valid
// ST_START | start bit (0) for one bit period
// ST_DATA  | payload bits, shift register drains LSB first
// ST_PARITY| parity bit (UART_TX_PARITY_EN builds only)
// ST_STOP  | STOP_BITS stop bits (1); tx_done on the very last cycle
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 50000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 txd,
   output logic                 tx_done
);

   localparam int unsigned   DIV       = calc_div(CLK_FREQ, BAUD);
   localparam int unsigned   BW        = cnt_width(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD > 1 || DIV < 2) begin : g_bad_cfg
      $error("uart_tx: unsupported parameter set");
   end

   uart_state_e          r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0]        r_bit_cnt;
   logic                 r_txd;
   logic                 r_tx_ready;
   logic                 r_tx_done;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
`endif

   logic w_accept;
   logic w_tick;
   logic w_tick_next;

   assign w_accept = tx_valid & r_tx_ready;

   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_accept),
      .o_tick     (w_tick),
      .o_tick_next(w_tick_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_txd      <= LINE_IDLE;
         r_tx_ready <= 1'b1;
         r_tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_tx_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_txd      <= LINE_IDLE;
               r_tx_ready <= 1'b1;
               if (w_accept) begin
                  r_state    <= ST_START;
                  r_shift    <= tx_data;
                  r_bit_cnt  <= '0;
                  r_txd      <= 1'b0;
                  r_tx_ready <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  r_parity   <= (^tx_data) ^ PARITY_ODD[0];
`endif
               end
            end
            ST_START: begin
               if (w_tick) begin
                  r_state   <= ST_DATA;
                  r_txd     <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= '0;
               end
            end
            ST_DATA: begin
               if (w_tick) begin
                  if (r_bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= ST_PARITY;
                     r_txd   <= r_parity;
`else
                     r_state <= ST_STOP;
                     r_txd   <= LINE_IDLE;
`endif
                     r_bit_cnt <= '0;
                  end else begin
                     r_txd     <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (w_tick) begin
                  r_state   <= ST_STOP;
                  r_txd     <= LINE_IDLE;
                  r_bit_cnt <= '0;
               end
            end
`endif
            ST_STOP: begin
               r_txd <= LINE_IDLE;
               // Done is registered one cycle early so it lands on the final stop cycle.
               if (r_bit_cnt == LAST_STOP) begin
                  if (w_tick_next) r_tx_done <= 1'b1;
                  if (w_tick) begin
                     r_state    <= ST_IDLE;
                     r_tx_ready <= 1'b1;
                  end
               end else if (w_tick) begin
                  r_bit_cnt <= r_bit_cnt + BW'(1);
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_txd      <= LINE_IDLE;
               r_tx_ready <= 1'b1;
            end
         endcase
      end
   end

   assign txd      = r_txd;
   assign tx_ready = r_tx_ready;
   assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model, per-cycle compare, line receiver
// and literal frame checks. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx;

   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 115200;
   localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int PAR      = 1;
   localparam int LIT_DONE = 4774;
`else
   localparam int PAR      = 0;
   localparam int LIT_DONE = 4340;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR + 1;
   localparam int FRAME_CYC  = FRAME_BITS * DIV;
   localparam int STOP_IDX   = 1 + 8 + PAR;
   localparam logic PAR_ODD  = 1'b0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready;
   logic       txd;
   logic       tx_done;

   int     n_vec = 0;
   int     n_err = 0;
   longint cyc = 0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD      (BAUD),
      .DATA_BITS (8),
      .STOP_BITS (1),
      .PARITY_ODD(0)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_valid(tx_valid),
      .tx_data (tx_data),
      .tx_ready(tx_ready),
      .txd     (txd),
      .tx_done (tx_done)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line level of bit slot idx of a frame carrying d.
   function automatic logic exp_bit(input int idx, input logic [7:0] d);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (PAR == 1 && idx == 9) return (^d) ^ PAR_ODD;
      return 1'b1;
   endfunction

   // Reference model: a frame is "busy" for FRAME_CYC cycles after an accept.
   logic       m_busy = 1'b0;
   int         m_cyc = 0;
   logic [7:0] m_data = 8'h00;
   int         m_done_cnt = 0;
   logic [7:0] exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_cyc  <= 0;
         exp_q.delete();
      end else if (m_busy) begin
         if (m_cyc == FRAME_CYC - 1) begin
            m_busy     <= 1'b0;
            m_done_cnt <= m_done_cnt + 1;
         end
         m_cyc <= m_cyc + 1;
      end else if (tx_valid) begin
         m_busy <= 1'b1;
         m_cyc  <= 0;
         m_data <= tx_data;
         exp_q.push_back(tx_data);
      end
   end

   always @(negedge clk) begin
      if (m_busy) begin
         chk("txd", txd, exp_bit(m_cyc / DIV, m_data));
         chk("tx_ready", tx_ready, 1'b0);
         chk("tx_done", tx_done, (m_cyc == FRAME_CYC - 1));
      end else begin
         chk("txd_idle", txd, 1'b1);
         chk("tx_ready_idle", tx_ready, 1'b1);
         chk("tx_done_idle", tx_done, 1'b0);
      end
   end

   // Mid-bit sampling receiver on txd (loopback).
   int         rx_busy = 0;
   int         rx_cnt = 0;
   int         rx_count = 0;
   int         rx_idx = 0;
   logic [7:0] rx_byte = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         rx_busy = 0;
      end else if (rx_busy == 0) begin
         if (txd == 1'b0) begin
            rx_busy = 1;
            rx_cnt  = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % DIV == DIV / 2) begin
            rx_idx = rx_cnt / DIV;
            if (rx_idx >= 1 && rx_idx <= 8) begin
               rx_byte[rx_idx-1] = txd;
            end else if (rx_idx == STOP_IDX) begin
               rx_busy = 0;
               rx_count++;
               chk("rx_stop", txd, 1'b1);
               chk("rx_pending", (exp_q.size() > 0), 1'b1);
               if (exp_q.size() > 0) chk("rx_data", rx_byte, exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] d, output longint acc_cyc);
      int w;
      w = 0;
      @(posedge clk); #2;
      tx_valid = 1'b1;
      tx_data  = d;
      do begin
         @(negedge clk);
         w++;
      end while (!tx_ready && w < 10000);
      if (w >= 10000) chk("send_ready_timeout", tx_ready, 1'b1);
      @(posedge clk);
      acc_cyc = cyc;
      #2;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!tx_ready && w < 10000);
      if (w >= 10000) chk("idle_timeout", tx_ready, 1'b1);
   endtask

   task automatic lit_frame(input logic [7:0] d, input logic [0:10] bits, input int done_at,
                            input bit inject);
      int     done_n;
      longint a;
      done_n = 0;
      send(d, a);
      for (int n = 1; n <= done_at + 2; n++) begin
         @(negedge clk);
         if (((n - 1) % DIV == DIV / 2) && ((n - 1) / DIV < FRAME_BITS))
            chk("lit_bit", txd, bits[(n-1)/DIV]);
         if (tx_done && done_n == 0) done_n = n;
         if (inject && n == 2000) begin
            tx_valid = 1'b1;
            tx_data  = 8'h3C;
         end
         if (inject && n == 2001) tx_valid = 1'b0;
      end
      chk("lit_done_cycle", done_n, done_at);
   endtask

   initial begin
      longint     a0, a1, a2;
      logic [0:10] bits;
      logic [7:0] d;

      rst_n = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("rst_txd", txd, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_done", tx_done, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (5000) @(posedge clk);

      // 8'h96 with a 8'h3C pulse mid-frame that must be ignored
`ifdef UART_TX_PARITY_EN
      bits = 11'b00110100101;
`else
      bits = 11'b00110100111;
`endif
      lit_frame(8'h96, bits, LIT_DONE, 1'b1);
      wait_idle();

      // back-to-back loopback
      send(8'h00, a0);
      send(8'hFF, a1);
      send(8'hA5, a2);
      chk("gap_0_1", a1 - a0, 64'(FRAME_CYC + 1));
      chk("gap_1_2", a2 - a1, 64'(FRAME_CYC + 1));
      wait_idle();
      repeat (5) @(posedge clk);
      chk("rx_count_loop", rx_count, 4);

      // reset during data bit 4 of 8'hC3 (bit 4 is 0)
      send(8'hC3, a0);
      repeat (5 * DIV + 100) @(negedge clk);
      chk("pre_rst_txd", txd, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_txd", txd, 1'b1);
      chk("mid_rst_done", tx_done, 1'b0);
      chk("mid_rst_ready", tx_ready, 1'b1);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
`ifdef UART_TX_PARITY_EN
      bits = 11'b01010101001;
`else
      bits = 11'b01010101011;
`endif
      lit_frame(8'h55, bits, LIT_DONE, 1'b0);
      wait_idle();

      bits = 11'b01110000011;
      lit_frame(8'h07, bits, LIT_DONE, 1'b0);
      wait_idle();

      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 40)) @(posedge clk);
         d = 8'($urandom);
         send(d, a0);
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(10, 4000)) @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            @(negedge clk);
            tx_valid = 1'b0;
         end
         wait_idle();
      end

      wait_idle();
      repeat (10) @(posedge clk);
      chk("rx_count_total", rx_count, m_done_cnt);
      chk("exp_q_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
